hw3_ser: RTL and testbench
==========================

// Module: hw3_ser
// PURPOSE
//   Parallel-to-serial front end for the HW3 pattern detector. Accepts WIDTH-bit
//   words over a valid/ready handshake. Shifts each word out one bit per clock
//   on o_data, which drives the detector's i_data.
//   Uses a 1-entry hold register plus a shift register, so consecutive words
//   stream with no gap bits. A pattern that spans a word boundary is therefore
//   still seen by the detector.
// PARAMETERS
//   WIDTH  8   bits per input word (>=2)
//   CNT_W  16  width of completed-word counter
// PORTS
//   i_clk        in   1      single clock, rising edge
//   i_rst_n      in   1      asynchronous, active-low reset
//   i_word       in   WIDTH  parallel word to serialize
//   i_valid      in   1      i_word valid
//   o_ready      out  1      block can accept i_word this cycle
//   o_data       out  1      serial bit stream (to detector i_data)
//   o_bit_valid  out  1      o_data carries a real word bit
//   o_busy       out  1      shift register or hold register occupied
//   o_word_cnt   out  CNT_W  number of words fully shifted out, wraps
// BEHAVIOUR
//   - Reset (async, i_rst_n=0): o_data=0, o_bit_valid=0, o_busy=0, o_word_cnt=0.
//     Hold and shift registers are emptied and the bit counter is cleared.
//     o_ready=1 after reset.
//   - Handshake: a word is accepted on a rising edge with i_valid && o_ready.
//     o_ready = !hold_full. It is registered-state only, with no combinational
//     path from i_valid. i_word must be held stable while i_valid && !o_ready.
//   - FSM: IDLE (shifter empty) / SHIFT (shifter loaded).
//     The load point is any edge where the state is IDLE, or the state is SHIFT
//     and bit_cnt==WIDTH-1 (last bit on the wire).
//     At the load point the shifter loads from the hold register if it is full;
//     otherwise it loads from i_word if the handshake fires.
//     If it loads nothing: a SHIFT ending goes to IDLE, and IDLE stays IDLE.
//     Words accepted but not loaded go to the hold register.
//   - Latency: a word accepted while IDLE with hold empty drives its first bit
//     on o_data in the cycle right after the accept edge, with o_bit_valid=1.
//     The bits occupy WIDTH consecutive cycles.
//   - Bit order: MSB first (i_word[WIDTH-1] first).
//   - Back-to-back: if hold is full, or a handshake fires at the last bit, the
//     next word's first bit follows the previous last bit with no gap cycle.
//   - Sustained throughput: 1 word / WIDTH cycles. o_ready drops while hold is full.
//   - Idle: o_data=0 and o_bit_valid=0. The idle bits are real 0s seen by the
//     detector.
//   - o_word_cnt increments at the edge that retires a word's last bit, and
//     wraps from 2^CNT_W-1 to 0.
//   - o_busy = (state==SHIFT) || hold_full.
//   - Simultaneous case: last bit, hold full and i_valid all at once. The
//     shifter takes the hold word. o_ready was 0, so i_word is not taken that
//     edge; the hold register frees and o_ready rises next cycle.
//   - Reset mid-word: the partial word and held word are discarded. No count
//     increment.
//   - All outputs are driven from flops. bit_cnt must not overflow for any WIDTH.
// CONFIGURATION
//   SER_LSB_FIRST_EN defined: each word is shifted LSB first (i_word[0] first).
//   SER_LSB_FIRST_EN undefined: MSB first.
//   Timing, handshake and counter behaviour are identical either way.
// TESTING
//   1 Assert reset mid-sim -> all outputs 0 at once, o_ready=1 after release.
//   2 With WIDTH=8 and idle, send 8'hDA once:
//     -> o_data = 1,1,0,1,1,0,1,0 over 8 cycles with o_bit_valid=1;
//     -> the detector's o_find pulses after bit 7;
//     -> o_word_cnt=1, then o_bit_valid=0.
//   3 Hold i_valid=1 and stream 8'hDB,8'h6D,8'hB6 -> 24 contiguous valid bits
//     with no gaps; o_ready low while hold is full; o_word_cnt=3.
//   4 Backpressure: present 3 words as fast as o_ready allows -> word 3 waits
//     with o_ready=0 until word 1's last bit, then is accepted, order is kept.
//   5 Reset pulse during bit 3 of 8'hFF -> next cycle o_bit_valid=0,
//     o_word_cnt=0, o_busy=0.
//   6 With SER_LSB_FIRST_EN, send 8'h5B -> o_data = 1,1,0,1,1,0,1,0, and the
//     detector o_find pulses after bit 7.

Source files
------------

// File: rtl/hw3_ser.sv
// hw3_ser: parallel-to-serial front end for the HW3 pattern detector (hold register + shifter, gapless streaming).
// Optional build macro SER_LSB_FIRST_EN selects LSB-first bit order; MSB-first when undefined.
module hw3_ser #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_word,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_data,
   output logic             o_bit_valid,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_word_cnt
);

   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q;
   logic [WIDTH-1:0]   hold_q;
   logic               holdFull_q, holdFull_d;
   logic [BW-1:0]      bitCnt_q;
   logic               data_q;
   logic               bitValid_q;
   logic               busy_q;
   logic               ready_q;
   logic [CNT_W-1:0]   wordCnt_q;

   logic               accept;
   logic               lastBit;
   logic               loadPoint;
   logic               loadHold;
   logic               loadIn;
   logic [WIDTH-1:0]   loadWord;
   logic               loadBit;
   logic [WIDTH-1:0]   loadRest;
   logic               nextBit;
   logic [WIDTH-1:0]   nextShift;

   // The shifter reloads only when empty or while its last bit is on the wire;
   // the hold register always has priority over a fresh handshake.
   always_comb begin
      accept    = i_valid && ready_q;
      lastBit   = (state_q == SHIFT) && (bitCnt_q == LAST);
      loadPoint = (state_q == IDLE) || lastBit;
      loadHold  = loadPoint && holdFull_q;
      loadIn    = loadPoint && !holdFull_q && accept;
      loadWord  = loadHold ? hold_q : i_word;
`ifdef SER_LSB_FIRST_EN
      loadBit   = loadWord[0];
      loadRest  = loadWord >> 1;
      nextBit   = shift_q[0];
      nextShift = shift_q >> 1;
`else
      loadBit   = loadWord[WIDTH-1];
      loadRest  = loadWord << 1;
      nextBit   = shift_q[WIDTH-1];
      nextShift = shift_q << 1;
`endif
      state_d = state_q;
      if (loadPoint) begin
         state_d = (loadHold || loadIn) ? SHIFT : IDLE;
      end
      holdFull_d = holdFull_q;
      if (loadHold) begin
         holdFull_d = 1'b0;
      end else if (accept && !loadIn) begin
         holdFull_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         hold_q     <= '0;
         holdFull_q <= 1'b0;
         bitCnt_q   <= '0;
         data_q     <= 1'b0;
         bitValid_q <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b1;
         wordCnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         holdFull_q <= holdFull_d;
         ready_q    <= !holdFull_d;
         busy_q     <= (state_d == SHIFT) || holdFull_d;
         if (accept && !loadIn) begin
            hold_q <= i_word;
         end
         if (lastBit) begin
            wordCnt_q <= wordCnt_q + CNT_W'(1);
         end
         // bitCnt_q only advances below LAST, so it can never wrap.
         if (loadHold || loadIn) begin
            data_q     <= loadBit;
            shift_q    <= loadRest;
            bitCnt_q   <= '0;
            bitValid_q <= 1'b1;
         end else if (loadPoint) begin
            data_q     <= 1'b0;
            bitCnt_q   <= '0;
            bitValid_q <= 1'b0;
         end else begin
            data_q     <= nextBit;
            shift_q    <= nextShift;
            bitCnt_q   <= bitCnt_q + BW'(1);
         end
      end
   end

   assign o_ready     = ready_q;
   assign o_data      = data_q;
   assign o_bit_valid = bitValid_q;
   assign o_busy      = busy_q;
   assign o_word_cnt  = wordCnt_q;

endmodule

// File: tb/tb_hw3_ser.sv
// tb_hw3_ser: checks hw3_ser against a bit-queue model of the serial stream.
// The model treats the serializer as a FIFO of pending bits drained one per clock.
module tb_hw3_ser;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             i_clk = 1'b0;
   logic             i_rst_n;
   logic [WIDTH-1:0] i_word;
   logic             i_valid;
   logic             o_ready;
   logic             o_data;
   logic             o_bit_valid;
   logic             o_busy;
   logic [CNT_W-1:0] o_word_cnt;

   int testCount = 0;
   int failCount = 0;

   // Reference model state: bits accepted but not yet on the wire, plus the wire bit.
   bit          mBits[$];
   bit          mLast[$];
   bit          curBit;
   bit          curValid;
   bit          curLast;
   int unsigned mCnt;

   hw3_ser #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_word     (i_word),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .o_data     (o_data),
      .o_bit_valid(o_bit_valid),
      .o_busy     (o_busy),
      .o_word_cnt (o_word_cnt)
   );

   always #5 i_clk = ~i_clk;

   function automatic void modelReset();
      mBits.delete();
      mLast.delete();
      curBit   = 1'b0;
      curValid = 1'b0;
      curLast  = 1'b0;
      mCnt     = 0;
   endfunction

   // Hold register is free exactly when fewer than one whole word is still pending.
   function automatic bit modelReady();
      return mBits.size() < WIDTH;
   endfunction

   function automatic void modelEdge(bit valid, logic [WIDTH-1:0] word, bit ready);
      if (curValid && curLast) mCnt = (mCnt + 1) % (1 << CNT_W);
      if (valid && ready) begin
         for (int k = 0; k < WIDTH; k++) begin
`ifdef SER_LSB_FIRST_EN
            mBits.push_back(word[k]);
`else
            mBits.push_back(word[WIDTH-1-k]);
`endif
            mLast.push_back(k == WIDTH - 1);
         end
      end
      if (mBits.size() > 0) begin
         curBit   = mBits.pop_front();
         curLast  = mLast.pop_front();
         curValid = 1'b1;
      end else begin
         curBit   = 1'b0;
         curLast  = 1'b0;
         curValid = 1'b0;
      end
   endfunction

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(string tag);
      checkOutput({tag, ".data"},      32'(o_data),      32'(curBit));
      checkOutput({tag, ".bit_valid"}, 32'(o_bit_valid), 32'(curValid));
      checkOutput({tag, ".ready"},     32'(o_ready),     32'(modelReady()));
      checkOutput({tag, ".busy"},      32'(o_busy),      32'(curValid));
      checkOutput({tag, ".word_cnt"},  32'(o_word_cnt),  32'(mCnt));
   endtask

   task automatic checkReset(string tag);
      checkOutput({tag, ".data"},      32'(o_data),      32'(0));
      checkOutput({tag, ".bit_valid"}, 32'(o_bit_valid), 32'(0));
      checkOutput({tag, ".busy"},      32'(o_busy),      32'(0));
      checkOutput({tag, ".word_cnt"},  32'(o_word_cnt),  32'(0));
   endtask

   // One clock: drive inputs, advance the model at the edge, compare #1 later.
   task automatic applyStimulus(string tag, bit valid, logic [WIDTH-1:0] word, output bit accepted);
      bit rdy;
      i_valid = valid;
      i_word  = word;
      rdy     = modelReady();
      @(posedge i_clk);
      modelEdge(valid, word, rdy);
      accepted = valid && rdy;
      #1;
      checkAll(tag);
   endtask

   task automatic randomPhase(int cycles);
      bit               acc;
      bit               pending;
      logic [WIDTH-1:0] w;
      pending = 1'b0;
      w       = '0;
      for (int c = 0; c < cycles; c++) begin
         if (!pending) begin
            w       = WIDTH'($urandom);
            pending = ($urandom_range(0, 3) != 0);
         end
         applyStimulus("rand", pending, w, acc);
         if (acc) pending = 1'b0;
      end
   endtask

   initial begin
      bit               acc;
      logic [WIDTH-1:0] words [3];
      int               idx;

      words[0] = 8'hDB;
      words[1] = 8'h6D;
      words[2] = 8'hB6;
      i_valid  = 1'b0;
      i_word   = '0;
      i_rst_n  = 1'b0;
      modelReset();
      #12;
      checkReset("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      applyStimulus("postReset", 1'b0, '0, acc);

      // Single word from idle, then drain.
      applyStimulus("wordDA", 1'b1, 8'hDA, acc);
      for (int c = 0; c < WIDTH + 2; c++) applyStimulus("drainDA", 1'b0, '0, acc);

      // Three words with i_valid held high: contiguous bits, hold-full backpressure.
      idx = 0;
      for (int c = 0; c < 60 && idx < 3; c++) begin
         applyStimulus("stream", 1'b1, words[idx], acc);
         if (acc) idx++;
      end
      checkOutput("streamAccepted", 32'(idx), 32'(3));
      for (int c = 0; c < 3 * WIDTH; c++) applyStimulus("drainStream", 1'b0, '0, acc);

      // Random traffic long enough to wrap the word counter.
      randomPhase(500);
      for (int c = 0; c < 3 * WIDTH; c++) applyStimulus("drainRand", 1'b0, '0, acc);

      // Reset during bit 3 of 8'hFF with a second word held.
      applyStimulus("wordFF", 1'b1, 8'hFF, acc);
      applyStimulus("holdFF", 1'b1, 8'h81, acc);
      applyStimulus("bitFF", 1'b0, '0, acc);
      applyStimulus("bitFF", 1'b0, '0, acc);
      #2;
      i_rst_n = 1'b0;
      modelReset();
      #1;
      checkReset("midReset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      applyStimulus("afterMidReset", 1'b0, '0, acc);
      applyStimulus("afterMidReset", 1'b0, '0, acc);

      randomPhase(150);
      for (int c = 0; c < 3 * WIDTH; c++) applyStimulus("drainEnd", 1'b0, '0, acc);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
